// File: rtl/swp_mem_seq.sv
// Memory-phase sequencer for SWP/SWPB.
// A decoded swap runs a locked read of [Rn], then a locked write of Rm to
// [Rn], then a one-cycle writeback of the loaded value to Rd. The pipeline
// is stalled through o_busy for the whole sequence.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             pipeline advance; qualifies i_swp_start in IDLE only
//   i_swp_start    swap instruction present in execute
//   i_swp_byte     1 = SWPB, 0 = SWP
//   i_addr         Rn (swap address)
//   i_wdata        Rm (store data)
//   i_rd           destination register index
//   i_mem_ready    memory accepts/completes the current request
//   i_mem_rdata    read data, valid with i_mem_ready during the read phase
//   o_busy         sequence in progress (stall request)
//   o_mem_req/we/lock/addr/be/wdata   memory request bus
//   o_wb_en/rd/data                   register writeback
//
// Every output is a flop loaded from the next state and the next captured
// operands, so nothing is combinationally dependent on i_swp_start.
module swp_mem_seq #(
  parameter int unsigned ADDR_W    = 32,
  parameter bit          RD_ROTATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i_swp_start,
  input  logic              i_swp_byte,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_rd,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic              o_mem_lock,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  output logic              o_wb_en,
  output logic [3:0]        o_wb_rd,
  output logic [31:0]       o_wb_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        rd_q, rd_d;
  logic              byte_q, byte_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              busy_d, req_d, we_d, lock_d, wb_en_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        be_d, wb_rd_d;
  logic [31:0]       mem_wdata_d, wb_data_d;

  // Load formatting: byte lane extract (zero-extended) or word rotate.
  function automatic logic [31:0] load_fmt(input logic [31:0] rdata,
                                           input logic [1:0]  lane,
                                           input logic        is_byte);
    logic [63:0] dbl;
    dbl = {rdata, rdata} >> {lane, 3'b000};
    if (is_byte)        return {24'h0, dbl[7:0]};
    else if (RD_ROTATE) return dbl[31:0];
    else                return rdata;
  endfunction

  // Next state and operand capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    byte_d  = byte_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (en && i_swp_start) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          rd_d    = i_rd;
          byte_d  = i_swp_byte;
          state_d = READ;
        end
      end
      READ: begin
        if (i_mem_ready) begin
          rdata_d = load_fmt(i_mem_rdata, addr_q[1:0], byte_q);
          state_d = WRITE;
        end
      end
      WRITE:   if (i_mem_ready) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the state being entered; lock spans READ and WRITE.
  always_comb begin
    busy_d      = 1'b0;
    req_d       = 1'b0;
    we_d        = 1'b0;
    lock_d      = 1'b0;
    mem_addr_d  = '0;
    be_d        = 4'h0;
    mem_wdata_d = 32'h0;
    wb_en_d     = 1'b0;
    wb_rd_d     = 4'h0;
    wb_data_d   = 32'h0;
    case (state_d)
      READ, WRITE: begin
        busy_d     = 1'b1;
        req_d      = 1'b1;
        lock_d     = 1'b1;
        mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
        be_d       = byte_d ? 4'(4'b0001 << addr_d[1:0]) : 4'hF;
        if (state_d == WRITE) begin
          we_d        = 1'b1;
          mem_wdata_d = byte_d ? {4{wdata_d[7:0]}} : wdata_d;
        end
      end
      WB: begin
        busy_d    = 1'b1;
        wb_en_d   = 1'b1;
        wb_rd_d   = rd_d;
        wb_data_d = rdata_d;
      end
      default: ;
    endcase
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rd_q        <= 4'h0;
      byte_q      <= 1'b0;
      rdata_q     <= 32'h0;
      o_busy      <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_lock  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= 4'h0;
      o_mem_wdata <= 32'h0;
      o_wb_en     <= 1'b0;
      o_wb_rd     <= 4'h0;
      o_wb_data   <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      byte_q      <= byte_d;
      rdata_q     <= rdata_d;
      o_busy      <= busy_d;
      o_mem_req   <= req_d;
      o_mem_we    <= we_d;
      o_mem_lock  <= lock_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_be    <= be_d;
      o_mem_wdata <= mem_wdata_d;
      o_wb_en     <= wb_en_d;
      o_wb_rd     <= wb_rd_d;
      o_wb_data   <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_swp_mem_seq.sv
// Bench for swp_mem_seq: table vectors, random swaps with random wait states,
// and hand sequences for enable gating, back-to-back starts and reset.
// A second instance with RD_ROTATE=0 shares the inputs; its writeback data
// is checked against the unrotated load.
module tb_swp_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, swp_start, swp_byte, mem_ready;
  logic [31:0] addr, wdata, mem_rdata;
  logic [3:0]  rd;

  logic        busy, mem_req, mem_we, mem_lock, wb_en;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be, wb_rd;

  logic        n_busy, n_mem_req, n_mem_we, n_mem_lock, n_wb_en;
  logic [31:0] n_mem_addr, n_mem_wdata, n_wb_data;
  logic [3:0]  n_mem_be, n_wb_rd;

  swp_mem_seq #(.ADDR_W(32), .RD_ROTATE(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .i_swp_start(swp_start), .i_swp_byte(swp_byte),
    .i_addr(addr), .i_wdata(wdata), .i_rd(rd), .i_mem_ready(mem_ready),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_lock(mem_lock), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .o_wb_en(wb_en), .o_wb_rd(wb_rd), .o_wb_data(wb_data)
  );

  swp_mem_seq #(.ADDR_W(32), .RD_ROTATE(1'b0)) dut_norot (
    .clk(clk), .rst(rst), .en(en), .i_swp_start(swp_start), .i_swp_byte(swp_byte),
    .i_addr(addr), .i_wdata(wdata), .i_rd(rd), .i_mem_ready(mem_ready),
    .i_mem_rdata(mem_rdata), .o_busy(n_busy), .o_mem_req(n_mem_req), .o_mem_we(n_mem_we),
    .o_mem_lock(n_mem_lock), .o_mem_addr(n_mem_addr), .o_mem_be(n_mem_be),
    .o_mem_wdata(n_mem_wdata), .o_wb_en(n_wb_en), .o_wb_rd(n_wb_rd), .o_wb_data(n_wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, req, we, lock;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
  } out_t;

  typedef struct {
    bit          is_byte;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  rd;
    int          rw, ww;
  } vec_t;

  localparam int PH_IDLE = 0, PH_READ = 1, PH_WRITE = 2, PH_WB = 3;

  int total = 0;
  int bad   = 0;

  // Value the swap should return to Rd, built byte by byte.
  function automatic logic [31:0] ref_load(bit byt, logic [31:0] a, logic [31:0] r, bit rot);
    logic [7:0]  b [4];
    logic [31:0] res;
    int k;
    k = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = r[8*i +: 8];
    if (byt) return 32'(b[k]);
    if (!rot) return r;
    res = 32'h0;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = b[(i + k) % 4];
    return res;
  endfunction

  // Expected outputs while the sequencer is in the given phase.
  function automatic out_t model(int ph, bit byt, logic [31:0] a, logic [31:0] wd,
                                 logic [3:0] r, logic [31:0] rdat, bit rot);
    out_t o;
    int k;
    o = '0;
    k = int'(a % 4);
    if (ph == PH_READ || ph == PH_WRITE) begin
      o.busy = 1'b1;
      o.req  = 1'b1;
      o.lock = 1'b1;
      o.addr = a - 32'(k);
      o.be   = byt ? 4'(1 << k) : 4'hF;
      if (ph == PH_WRITE) begin
        o.we    = 1'b1;
        o.wdata = byt ? 32'(wd[7:0]) * 32'h01010101 : wd;
      end
    end else if (ph == PH_WB) begin
      o.busy    = 1'b1;
      o.wb_en   = 1'b1;
      o.wb_rd   = r;
      o.wb_data = ref_load(byt, a, rdat, rot);
    end
    return o;
  endfunction

  function automatic out_t actual();
    return {busy, mem_req, mem_we, mem_lock, mem_addr, mem_be, mem_wdata,
            wb_en, wb_rd, wb_data};
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_norot(input string name, input logic [31:0] exp);
    total++;
    if (n_wb_data !== exp || n_wb_en !== 1'b1) begin
      bad++;
      $display("FAIL %s @%0t: got wb_en=%b wb_data=%h want wb_en=1 wb_data=%h",
               name, $time, n_wb_en, n_wb_data, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full swap with the given read/write wait-state counts.
  task automatic do_swap(input vec_t v, input string tag);
    en = 1'b1; swp_start = 1'b1; swp_byte = v.is_byte;
    addr = v.addr; wdata = v.wdata; rd = v.rd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    step();
    swp_start = 1'b0; en = 1'($urandom);
    for (int i = 0; i <= v.rw; i++) begin
      check({tag, "_read"}, model(PH_READ, v.is_byte, v.addr, v.wdata, v.rd, v.rdata, 1'b1));
      mem_ready = (i == v.rw);
      mem_rdata = mem_ready ? v.rdata : $urandom;
      step();
    end
    for (int i = 0; i <= v.ww; i++) begin
      check({tag, "_write"}, model(PH_WRITE, v.is_byte, v.addr, v.wdata, v.rd, v.rdata, 1'b1));
      mem_ready = (i == v.ww);
      mem_rdata = $urandom;
      step();
    end
    check({tag, "_wb"}, model(PH_WB, v.is_byte, v.addr, v.wdata, v.rd, v.rdata, 1'b1));
    check_norot({tag, "_wb_norot"}, ref_load(v.is_byte, v.addr, v.rdata, 1'b0));
    mem_ready = 1'($urandom);
    step();
    check({tag, "_idle"}, model(PH_IDLE, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1));
    mem_ready = 1'b0;
  endtask

  vec_t vecs [5];
  int   b2b_ph [8] = '{PH_READ, PH_WRITE, PH_WB, PH_IDLE, PH_READ, PH_WRITE, PH_WB, PH_IDLE};

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 32'hCAFE_BABE, 32'h1234_5678, 4'd3, 0, 0};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'hCAFE_BABE, 32'h1234_5678, 4'd5, 2, 3};
    vecs[2] = '{1'b1, 32'h0000_1002, 32'h0000_00AB, 32'h1122_3344, 4'd7, 0, 0};
    vecs[3] = '{1'b0, 32'h0000_2001, 32'h5566_7788, 32'h1122_3344, 4'd9, 1, 0};
    vecs[4] = '{1'b1, 32'h0000_1003, 32'h1234_56CD, 32'hA1B2_C3D4, 4'd15, 1, 2};

    rst = 1'b1; en = 1'b0; swp_start = 1'b0; swp_byte = 1'b0;
    addr = 32'h0; wdata = 32'h0; rd = 4'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) do_swap(vecs[i], $sformatf("vec%0d", i));

    // Start with en low is ignored.
    en = 1'b0; swp_start = 1'b1; addr = 32'h40; wdata = 32'h1; rd = 4'd1;
    step();
    check("en0_ignore_a", '0);
    step();
    check("en0_ignore_b", '0);

    // Start held high: second accept only after WB, READ again at cycle 5.
    en = 1'b1; swp_start = 1'b1; swp_byte = 1'b0; addr = 32'h0000_3000;
    wdata = 32'hDEAD_BEEF; rd = 4'd6; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("b2b_c%0d", c + 1),
            model(b2b_ph[c], 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'd6, 32'h0BAD_F00D, 1'b1));
      if (c == 4) swp_start = 1'b0;
      step();
    end
    mem_ready = 1'b0;

    // Reset during a stalled WRITE.
    en = 1'b1; swp_start = 1'b1; swp_byte = 1'b0; addr = 32'h0000_4000;
    wdata = 32'h7777_8888; rd = 4'd2; mem_ready = 1'b0;
    step();
    swp_start = 1'b0;
    check("rst_seq_read", model(PH_READ, 1'b0, 32'h4000, 32'h7777_8888, 4'd2, 32'h0, 1'b1));
    mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
    step();
    mem_ready = 1'b0;
    check("rst_seq_write", model(PH_WRITE, 1'b0, 32'h4000, 32'h7777_8888, 4'd2, 32'h0, 1'b1));
    step();
    #2 rst = 1'b1;
    #1 check("rst_async", '0);
    mem_ready = 1'b1;
    step();
    check("rst_no_wb", '0);
    rst = 1'b0;
    step();
    check("rst_idle", '0);
    mem_ready = 1'b0;
    do_swap(vecs[0], "post_rst");

    // Random swaps.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.is_byte = 1'($urandom);
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.rdata   = $urandom;
      v.rd      = 4'($urandom);
      v.rw      = int'($urandom_range(0, 3));
      v.ww      = int'($urandom_range(0, 3));
      do_swap(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swp_mem_seq.md
Name: swp_mem_seq

Overview:
Memory-phase sequencer for SWP/SWPB. It sits directly downstream of the swap hold controller in the execute/memory stage. On a decoded swap it performs the locked read of [Rn], then the locked write of Rm to [Rn], then a one-cycle register writeback of the loaded value to Rd. It drives o_busy to stall the pipeline for the whole sequence.

Parameters:
ADDR_W, 32, memory address width (data path fixed at 32 bits, 4 byte lanes)
RD_ROTATE, 1, 1 = unaligned word read is rotated right by 8*addr[1:0] (ARMv4 LDR semantics); 0 = no rotation

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  pipeline advance enable; qualifies acceptance of i_swp_start only
i_swp_start  in  1  swap instruction present in execute stage
i_swp_byte  in  1  1 = SWPB, 0 = SWP (word)
i_addr  in  ADDR_W  Rn value (swap address)
i_wdata  in  32  Rm value (store data)
i_rd  in  4  destination register index
i_mem_ready  in  1  memory accepts/completes the current request this cycle
i_mem_rdata  in  32  read data, valid when i_mem_ready and read phase
o_busy  out  1  sequence in progress (stall request)
o_mem_req  out  1  memory request valid
o_mem_we  out  1  1 = write, 0 = read
o_mem_lock  out  1  bus lock, held across the read and write phases
o_mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  write data
o_wb_en  out  1  register writeback strobe (one cycle)
o_wb_rd  out  4  writeback register index
o_wb_data  out  32  writeback data

Behaviour:
- Reset: state IDLE; all outputs 0; captured addr/wdata/rd/byte registers 0.
- States: IDLE, READ, WRITE, WB. All outputs are registered or decoded from state plus captured registers only, never from i_swp_start.
- IDLE: if en && i_swp_start, capture i_addr, i_wdata, i_rd, i_swp_byte, then go to READ. Otherwise stay. i_swp_start with en=0 is ignored.
- READ: o_mem_req=1, we=0, lock=1.
  - On i_mem_ready: capture processed read data, go to WRITE.
  - Without ready: hold all request outputs stable.
- WRITE: o_mem_req=1, we=1, lock=1. On i_mem_ready go to WB.
- Lock is continuous from READ entry through WRITE completion; it never drops between the phases.
- WB: o_wb_en=1, o_wb_rd=captured rd, o_wb_data=captured read data, req=0, lock=0. Next state is IDLE unconditionally; a new start is not accepted in WB.
- o_busy=1 in READ, WRITE and WB; 0 in IDLE.
- Latency: start accepted at edge 0, and with zero wait states READ=cycle 1, WRITE=cycle 2, WB=cycle 3, IDLE=cycle 4. Each wait cycle extends its phase by one.
- Byte (SWPB):
  - o_mem_be = 4'b0001 << addr[1:0] in both phases.
  - wdata = {4{Rm[7:0]}}.
  - Read data = byte lane addr[1:0] of rdata, zero-extended to 32 bits.
- Word (SWP):
  - o_mem_be = 4'hF.
  - wdata = Rm.
  - Read data = rdata rotated right by 8*addr[1:0] when RD_ROTATE=1, else rdata unmodified.
- o_mem_wdata is driven only in WRITE and is 0 elsewhere. o_mem_addr/be are driven in READ and WRITE and are 0 elsewhere.
- en is ignored after acceptance: the bus phases progress regardless of en.
- Reset mid-sequence: immediate return to IDLE. req, lock, busy and wb_en fall asynchronously, and no writeback occurs.

Test Plan:
- Word swap, zero wait: addr=0x1000, Rm=0xCAFEBABE, rdata=0x12345678, rd=3. Required response:
  - READ cycle 1 (we=0, lock=1, be=F).
  - WRITE cycle 2 (wdata=0xCAFEBABE, lock=1).
  - WB cycle 3 (wb_rd=3, wb_data=0x12345678).
  - busy=1 for exactly 3 cycles.
- Wait states: ready low for 2 cycles in READ and 3 cycles in WRITE → req/addr/we/be held stable, lock never drops, WB on cycle 1+3+4=8.
- SWPB at addr=0x1002, Rm=0x000000AB, rdata=0x11223344 → be=4'b0100, wdata=0xABABABAB, wb_data=0x00000022.
- Unaligned word read at addr=0x2001, rdata=0x11223344 → wb_data=0x44112233 with RD_ROTATE=1; 0x11223344 with RD_ROTATE=0; o_mem_addr=0x2000.
- Enable/back-to-back: start with en=0 → ignored, busy stays 0. Start held high through the sequence → second accept only in IDLE after WB, i.e. READ again at cycle 5.
- rst asserted during WRITE with ready low → req/lock/busy=0 asynchronously, no wb_en pulse; after release, IDLE accepts a new start.
